spi_word_packer: RTL and testbench

//  Downstream of the SPI peripheral receiver: consumes its byte stream (data_out/data_valid_out)
//  and packs BYTES_PER_WORD consecutive bytes into one word for the ballot/ciphertext datapath.

---
 rtl/spi_pkg.sv | 12 +
 rtl/idle_timer.sv | 37 +++
 rtl/spi_word_packer.sv | 148 ++++++++++++++
 tb/tb_spi_word_packer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI-side types: default byte width and the output-holding state encoding.
package spi_pkg;

    localparam int unsigned BYTE_WIDTH_DEF = 8;

    // Output register occupancy, reused by other SPI framers.
    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

endpackage : spi_pkg

// File: rtl/idle_timer.sv
// Idle watchdog counter: counts enabled cycles and flags expiry on the
// MAX_COUNT-th consecutive enabled, uncleared cycle.
//  clk_in      in   clock
//  rst_in      in   synchronous active-low reset
//  clear_in    in   restart the count (has priority over expiry)
//  enable_in   in   count this cycle
//  expired_out out  combinational: this cycle is the MAX_COUNT-th idle cycle
module idle_timer #(
    parameter int unsigned MAX_COUNT = 16
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic clear_in,
    input  logic enable_in,
    output logic expired_out
);

    localparam int unsigned CNT_W = $clog2(MAX_COUNT);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_max;

    assign w_at_max    = (r_cnt == CNT_W'(MAX_COUNT - 1));
    assign expired_out = enable_in && !clear_in && w_at_max;

    // Counter restarts after expiry so the owner sees a single event.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_cnt <= '0;
        end else if (clear_in || expired_out) begin
            r_cnt <= '0;
        end else if (enable_in) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule : idle_timer

// File: rtl/spi_word_packer.sv
// Packs consecutive SPI bytes into words (first byte in MSBs) with a
// valid/ready output, idle-timeout discard of partial words, and a sticky
// overflow flag for words dropped under back-pressure.
//  clk_in          in   system clock
//  rst_in          in   synchronous active-low reset
//  byte_in         in   received byte
//  byte_valid_in   in   single-cycle byte strobe
//  word_out        out  packed word
//  word_valid_out  out  word_out valid, held until accepted
//  word_ready_in   in   consumer accepts when valid && ready
//  byte_count_out  out  bytes held in the current partial word
//  timeout_out     out  1-cycle pulse: partial word discarded on idle timeout
//  overflow_out    out  sticky: a completed word was dropped
module spi_word_packer
    import spi_pkg::*;
#(
    parameter int unsigned BYTE_WIDTH     = BYTE_WIDTH_DEF,
    parameter int unsigned BYTES_PER_WORD = 4,
    parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
    input  logic                                  clk_in,
    input  logic                                  rst_in,
    input  logic [BYTE_WIDTH-1:0]                 byte_in,
    input  logic                                  byte_valid_in,
    output logic [BYTE_WIDTH*BYTES_PER_WORD-1:0]  word_out,
    output logic                                  word_valid_out,
    input  logic                                  word_ready_in,
    output logic [$clog2(BYTES_PER_WORD)-1:0]     byte_count_out,
    output logic                                  timeout_out,
    output logic                                  overflow_out
);

    localparam int unsigned WORD_WIDTH = BYTE_WIDTH * BYTES_PER_WORD;
    localparam int unsigned ACC_WIDTH  = WORD_WIDTH - BYTE_WIDTH;
    localparam int unsigned CNT_W      = $clog2(BYTES_PER_WORD);

    // Only the bytes of the partial word are stored; the final byte is
    // taken straight from byte_in when the word completes.
    logic [ACC_WIDTH-1:0]  r_acc;
    logic [CNT_W-1:0]      r_count;
    logic [WORD_WIDTH-1:0] r_word;
    logic                  r_timeout;
    logic                  r_overflow;
    out_state_t            r_state;
    out_state_t            w_next_state;

    logic [WORD_WIDTH-1:0] w_assembled;
    logic                  w_complete;
    logic                  w_load;
    logic                  w_drop;
    logic                  w_expired;
    logic                  w_timer_clear;
    logic                  w_timer_en;

    assign w_assembled = {r_acc, byte_in};
    assign w_complete  = byte_valid_in && (r_count == CNT_W'(BYTES_PER_WORD - 1));

    // Timer runs only while a partial word is pending; any byte restarts it.
    assign w_timer_en    = (r_count != '0);
    assign w_timer_clear = byte_valid_in || (r_count == '0);

    idle_timer #(
        .MAX_COUNT (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .clear_in    (w_timer_clear),
        .enable_in   (w_timer_en),
        .expired_out (w_expired)
    );

    // Output state register.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state <= OUT_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Output next-state: a completed word either loads or is dropped.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            OUT_EMPTY: begin
                if (w_complete) begin
                    w_next_state = OUT_FULL;
                    w_load       = 1'b1;
                end
            end
            OUT_FULL: begin
                if (w_complete) begin
                    // Acceptance in the same cycle frees the register without a bubble.
                    if (word_ready_in) begin
                        w_load = 1'b1;
                    end else begin
                        w_drop = 1'b1;
                    end
                end else if (word_ready_in) begin
                    w_next_state = OUT_EMPTY;
                end
            end
            default: begin
                w_next_state = OUT_EMPTY;
            end
        endcase
    end

    // Accumulator, byte counter, output word and status flags.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_acc      <= '0;
            r_count    <= '0;
            r_word     <= '0;
            r_timeout  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_timeout <= w_expired;
            if (byte_valid_in) begin
                if (w_complete) begin
                    r_acc   <= '0;
                    r_count <= '0;
                end else begin
                    r_acc   <= w_assembled[ACC_WIDTH-1:0];
                    r_count <= r_count + 1'b1;
                end
            end else if (w_expired) begin
                r_acc   <= '0;
                r_count <= '0;
            end
            if (w_load) begin
                r_word <= w_assembled;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign word_out       = r_word;
    assign word_valid_out = (r_state == OUT_FULL);
    assign byte_count_out = r_count;
    assign timeout_out    = r_timeout;
    assign overflow_out   = r_overflow;

endmodule : spi_word_packer

// File: tb/tb_spi_word_packer.sv
// Bench for spi_word_packer: directed scenarios plus random traffic, checked
// against a byte-list reference model and a queue of expected accepted words.
module tb_spi_word_packer;

    localparam int unsigned BW  = 8;
    localparam int unsigned BPW = 4;
    localparam int unsigned TO  = 16;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [7:0]  byte_in;
    logic        byte_valid_in;
    logic [31:0] word_out;
    logic        word_valid_out;
    logic        word_ready_in;
    logic [1:0]  byte_count_out;
    logic        timeout_out;
    logic        overflow_out;

    always #5 clk_in = ~clk_in;

    spi_word_packer #(
        .BYTE_WIDTH     (BW),
        .BYTES_PER_WORD (BPW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .byte_in        (byte_in),
        .byte_valid_in  (byte_valid_in),
        .word_out       (word_out),
        .word_valid_out (word_valid_out),
        .word_ready_in  (word_ready_in),
        .byte_count_out (byte_count_out),
        .timeout_out    (timeout_out),
        .overflow_out   (overflow_out)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state (after the most recent clock edge).
    logic [7:0]  m_part[$];
    int          m_idle;
    logic [31:0] m_word;
    logic        m_valid;
    logic        m_ovf;
    logic        m_to;
    logic [31:0] exp_q[$];
    bit          mon_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behaviour at one clock edge given the inputs present at that edge.
    task automatic model_step(input logic r, input logic v, input logic [7:0] b, input logic rd);
        logic        done;
        logic [31:0] w;
        done = 1'b0;
        w    = '0;
        if (!r) begin
            m_part.delete();
            exp_q.delete();
            m_idle  = 0;
            m_word  = '0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_to    = 1'b0;
        end else begin
            m_to = 1'b0;
            if (v) begin
                m_idle = 0;
                m_part.push_back(b);
                if (m_part.size() == BPW) begin
                    foreach (m_part[k]) w = (w << 8) | 32'(m_part[k]);
                    m_part.delete();
                    done = 1'b1;
                end
            end else if (m_part.size() != 0) begin
                m_idle++;
                if (m_idle == TO) begin
                    m_part.delete();
                    m_idle = 0;
                    m_to   = 1'b1;
                end
            end else begin
                m_idle = 0;
            end
            if (done) begin
                if (!m_valid || rd) begin
                    m_word  = w;
                    m_valid = 1'b1;
                    exp_q.push_back(w);
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (m_valid && rd) begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [7:0] b, input logic rd);
        rst_in        = r;
        byte_valid_in = v;
        byte_in       = b;
        word_ready_in = rd;
        @(posedge clk_in);
        model_step(r, v, b, rd);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w, input logic rd);
        logic [31:0] t;
        t = w;
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b1, t[31:24], rd);
            t = t << 8;
        end
    endtask

    task automatic idle(input int n, input logic rd);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 8'h00, rd);
    endtask

    // Monitor: compares outputs mid-cycle and pops expected words on handshake.
    initial begin
        forever begin
            @(negedge clk_in);
            if (mon_on) begin
                chk("valid", 32'(word_valid_out), 32'(m_valid));
                chk("count", 32'(byte_count_out), 32'(m_part.size()));
                chk("timeout", 32'(timeout_out), 32'(m_to));
                chk("overflow", 32'(overflow_out), 32'(m_ovf));
                chk("word_out", word_out, m_word);
                if (word_valid_out && word_ready_in) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL accept: got %h expected no word at %0t", word_out, $time);
                    end else begin
                        chk("accept", word_out, exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        logic       r, v, rd;
        logic [7:0] b;
        rst_in        = 1'b0;
        byte_valid_in = 1'b0;
        byte_in       = '0;
        word_ready_in = 1'b0;
        step(1'b0, 1'b0, 8'h00, 1'b0);
        mon_on = 1'b1;
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Basic packing with ready high.
        send_word(32'hDEADBEEF, 1'b1);
        idle(3, 1'b1);

        // Back-pressure overflow, then drain.
        send_word(32'h01020304, 1'b0);
        send_word(32'h05060708, 1'b0);
        idle(2, 1'b0);
        idle(3, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Ready on the exact completion cycle of the second word.
        send_word(32'h01020304, 1'b0);
        step(1'b1, 1'b1, 8'h05, 1'b0);
        step(1'b1, 1'b1, 8'h06, 1'b0);
        step(1'b1, 1'b1, 8'h07, 1'b0);
        step(1'b1, 1'b1, 8'h08, 1'b1);
        idle(2, 1'b1);

        // Idle timeout discards a partial word.
        step(1'b1, 1'b1, 8'hAA, 1'b1);
        step(1'b1, 1'b1, 8'hBB, 1'b1);
        idle(18, 1'b1);
        send_word(32'h11223344, 1'b1);
        idle(2, 1'b1);

        // Byte on the expiry cycle wins over the timeout.
        step(1'b1, 1'b1, 8'hAA, 1'b1);
        step(1'b1, 1'b1, 8'hBB, 1'b1);
        idle(TO - 1, 1'b1);
        step(1'b1, 1'b1, 8'hCC, 1'b1);
        idle(20, 1'b1);

        // Reset mid-word with a strobe present.
        step(1'b1, 1'b1, 8'h12, 1'b0);
        step(1'b1, 1'b1, 8'h34, 1'b0);
        step(1'b0, 1'b1, 8'h56, 1'b1);
        send_word(32'hCAFEF00D, 1'b1);
        idle(2, 1'b1);

        // Random traffic with alternating dense/sparse and ready phases.
        for (int i = 0; i < 4000; i++) begin
            r  = ($urandom_range(0, 499) != 0);
            v  = (((i / 250) % 2) == 1) ? ($urandom_range(0, 19) == 0)
                                        : ($urandom_range(0, 1) == 1);
            b  = 8'($urandom);
            rd = (((i / 400) % 2) == 1) ? ($urandom_range(0, 3) == 0)
                                        : ($urandom_range(0, 3) != 0);
            step(r, v, b, rd);
        end
        idle(3, 1'b1);

        @(negedge clk_in);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_spi_word_packer
